// File: rtl/main_memory.sv
// main_memory: word-addressed memory responder on the L2 cache memory-side bus.
// Fixed read latency, optional power-on pattern fill, out-of-range protection
// and 16-bit read/write transaction counters.
module main_memory #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 15,
    parameter int DEPTH         = 32768,
    parameter int READ_LATENCY  = 1,
    parameter int INIT_ON_RESET = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] MM_word_address,
    input  logic              MM_read_request,
    input  logic              MM_write_request,
    input  logic [DATA_W-1:0] MM_write_word,
    output logic [DATA_W-1:0] MM_read_word,
    output logic              mm_ready,
    output logic              mm_error,
    output logic [31:0]       mm_statistics
);

    // Index width of the implemented array; addresses are compared at full
    // width (plus one bit so DEPTH itself is representable) for range checks.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W + 1)'(DEPTH - 1);

    // Number of address-carrying pipeline stages ahead of the output stage.
    localparam int PIPE_N = (READ_LATENCY > 1) ? (READ_LATENCY - 1) : 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    localparam logic [DATA_W-1:0] OOR_WORD = DATA_W'(32'hDEADBEEF);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]        state_q, state_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic              error_q, error_d;
    logic [15:0]       rd_cnt_q, rd_cnt_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0] read_word_q;

    // Storage: never reset, so contents survive a reset when no fill is used.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic              run;
    logic              addr_in_range;
    logic              acc_rd;
    logic              acc_wr;
    logic              run_we;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [15:0]       fill_lo;
    logic [31:0]       fill_pattern;

    assign run           = (state_q == ST_RUN);
    assign addr_in_range = ({1'b0, MM_word_address} < DEPTH_L);
    assign acc_rd        = run & MM_read_request;
    assign acc_wr        = run & MM_write_request;
    assign run_we        = acc_wr & addr_in_range;

    // Fill pattern for word i is {i[15:0], ~i[15:0]}.
    assign fill_lo      = 16'(fill_q);
    assign fill_pattern = {fill_lo, ~fill_lo};

    // Single write port shared by the init fill and bus writes; nothing is
    // written while reset is held.
    assign mem_we    = reset & (run ? run_we : 1'b1);
    assign mem_waddr = run ? MM_word_address[IDX_W-1:0] : fill_q[IDX_W-1:0];
    assign mem_wdata = run ? MM_write_word : DATA_W'(fill_pattern);

    // ------------------------------------------------------------------
    // Next-state logic: fill sequencing, sticky error, counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        error_d  = error_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (!run) begin
            if (fill_q == LAST_L) begin
                state_d = ST_RUN;
                fill_d  = '0;
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end else begin
            if ((acc_rd | acc_wr) && !addr_in_range) begin
                error_d = 1'b1;
            end
            if (acc_rd) begin
                rd_cnt_d = rd_cnt_q + 16'd1;
            end
            if (acc_wr) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RESET;
            fill_q   <= '0;
            error_q  <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            error_q  <= error_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Array write port (fill or bus write).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: the array is sampled only at the output stage, so any
    // write landing while a read is in flight is returned.
    // ------------------------------------------------------------------
    logic              out_vld;
    logic [ADDR_W-1:0] out_addr;
    logic              out_inr;

    generate
        if (READ_LATENCY > 1) begin : g_pipe
            logic              vld_q  [PIPE_N];
            logic [ADDR_W-1:0] addr_q [PIPE_N];
            logic              inr_q  [PIPE_N];

            // Shift {valid, address, in-range} toward the output stage.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < PIPE_N; s++) begin
                        vld_q[s]  <= 1'b0;
                        addr_q[s] <= '0;
                        inr_q[s]  <= 1'b0;
                    end
                end else begin
                    vld_q[0]  <= acc_rd;
                    addr_q[0] <= MM_word_address;
                    inr_q[0]  <= addr_in_range;
                    for (int s = 1; s < PIPE_N; s++) begin
                        vld_q[s]  <= vld_q[s-1];
                        addr_q[s] <= addr_q[s-1];
                        inr_q[s]  <= inr_q[s-1];
                    end
                end
            end

            assign out_vld  = vld_q[PIPE_N-1];
            assign out_addr = addr_q[PIPE_N-1];
            assign out_inr  = inr_q[PIPE_N-1];
        end else begin : g_direct
            assign out_vld  = acc_rd;
            assign out_addr = MM_word_address;
            assign out_inr  = addr_in_range;
        end
    endgenerate

    // Output stage: registered array read with write-first bypass for a
    // same-edge write; out-of-range entries return a marker word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_word_q <= '0;
        end else if (out_vld) begin
            if (!out_inr) begin
                read_word_q <= OOR_WORD;
            end else if (run_we && (MM_word_address == out_addr)) begin
                read_word_q <= MM_write_word;
            end else begin
                read_word_q <= mem_q[out_addr[IDX_W-1:0]];
            end
        end
    end

    assign MM_read_word  = read_word_q;
    assign mm_ready      = run;
    assign mm_error      = error_q;
    assign mm_statistics = {rd_cnt_q, wr_cnt_q};

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed checks of main_memory across four configurations:
// defaults, DEPTH=1024, init fill with DEPTH=16, and READ_LATENCY=3.
module tb_main_memory;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n [N];
    logic [14:0] addr  [N];
    logic        rd    [N];
    logic        wr    [N];
    logic [31:0] wdata [N];
    logic [31:0] rword [N];
    logic        ready [N];
    logic        err   [N];
    logic [31:0] stats [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    main_memory u_def (
        .clk(clk), .reset(rst_n[0]), .MM_word_address(addr[0]),
        .MM_read_request(rd[0]), .MM_write_request(wr[0]), .MM_write_word(wdata[0]),
        .MM_read_word(rword[0]), .mm_ready(ready[0]), .mm_error(err[0]),
        .mm_statistics(stats[0])
    );

    main_memory #(.DEPTH(1024)) u_oor (
        .clk(clk), .reset(rst_n[1]), .MM_word_address(addr[1]),
        .MM_read_request(rd[1]), .MM_write_request(wr[1]), .MM_write_word(wdata[1]),
        .MM_read_word(rword[1]), .mm_ready(ready[1]), .mm_error(err[1]),
        .mm_statistics(stats[1])
    );

    main_memory #(.DEPTH(16), .INIT_ON_RESET(1)) u_init (
        .clk(clk), .reset(rst_n[2]), .MM_word_address(addr[2]),
        .MM_read_request(rd[2]), .MM_write_request(wr[2]), .MM_write_word(wdata[2]),
        .MM_read_word(rword[2]), .mm_ready(ready[2]), .mm_error(err[2]),
        .mm_statistics(stats[2])
    );

    main_memory #(.READ_LATENCY(3)) u_l3 (
        .clk(clk), .reset(rst_n[3]), .MM_word_address(addr[3]),
        .MM_read_request(rd[3]), .MM_write_request(wr[3]), .MM_write_word(wdata[3]),
        .MM_read_word(rword[3]), .mm_ready(ready[3]), .mm_error(err[3]),
        .mm_statistics(stats[3])
    );

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0;
            rd[i]    = 1'b0;
            wr[i]    = 1'b0;
            addr[i]  = '0;
            wdata[i] = '0;
        end
        step();
        step();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rword[i] !== 32'h0) begin
                $display("FAIL reset_rword dut%0d got %h exp %h", i, rword[i], 32'h0);
                errors++;
            end
            checks++;
            if (stats[i] !== 32'h0) begin
                $display("FAIL reset_stats dut%0d got %h exp %h", i, stats[i], 32'h0);
                errors++;
            end
            checks++;
            if (err[i] !== 1'b0) begin
                $display("FAIL reset_error dut%0d got %b exp 0", i, err[i]);
                errors++;
            end
            checks++;
            if (ready[i] !== ((i == 2) ? 1'b0 : 1'b1)) begin
                $display("FAIL reset_ready dut%0d got %b exp %b", i, ready[i], (i == 2) ? 1'b0 : 1'b1);
                errors++;
            end
        end
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        step();
        $display("reset: all instances released");
    endtask

    task automatic test_write_read();
        wr[0] = 1'b1; addr[0] = 15'h0123; wdata[0] = 32'hA5A5_0001;
        step();
        wr[0] = 1'b0; rd[0] = 1'b1;
        step();
        rd[0] = 1'b0;
        $display("write_read: addr 0123 -> %h", rword[0]);
        checks++;
        if (rword[0] !== 32'hA5A5_0001) begin
            $display("FAIL write_read_data got %h exp %h", rword[0], 32'hA5A5_0001);
            errors++;
        end
        checks++;
        if (stats[0] !== 32'h0001_0001) begin
            $display("FAIL write_read_stats got %h exp %h", stats[0], 32'h0001_0001);
            errors++;
        end
    endtask

    task automatic test_refill_burst();
        for (int i = 0; i < 16; i++) begin
            wr[0] = 1'b1; addr[0] = 15'h1230 + 15'(i); wdata[0] = 32'(i);
            step();
        end
        wr[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd[0] = 1'b1; addr[0] = 15'h1230 + 15'(i);
            step();
            $display("burst: addr %h -> %h", addr[0], rword[0]);
            checks++;
            if (rword[0] !== 32'(i)) begin
                $display("FAIL burst_word%0d got %h exp %h", i, rword[0], 32'(i));
                errors++;
            end
        end
        rd[0] = 1'b0;
        checks++;
        if (stats[0] !== 32'h0011_0011) begin
            $display("FAIL burst_stats got %h exp %h", stats[0], 32'h0011_0011);
            errors++;
        end
    endtask

    task automatic test_simultaneous();
        wr[0] = 1'b1; rd[0] = 1'b1; addr[0] = 15'h0040; wdata[0] = 32'h0000_BEEF;
        step();
        wr[0] = 1'b0; rd[0] = 1'b0; addr[0] = 15'h0123;
        $display("simultaneous: addr 0040 -> %h", rword[0]);
        checks++;
        if (rword[0] !== 32'h0000_BEEF) begin
            $display("FAIL simul_data got %h exp %h", rword[0], 32'h0000_BEEF);
            errors++;
        end
        checks++;
        if (stats[0] !== 32'h0012_0012) begin
            $display("FAIL simul_stats got %h exp %h", stats[0], 32'h0012_0012);
            errors++;
        end
        step();
        checks++;
        if (rword[0] !== 32'h0000_BEEF) begin
            $display("FAIL idle_hold got %h exp %h", rword[0], 32'h0000_BEEF);
            errors++;
        end
    endtask

    task automatic test_out_of_range();
        wr[1] = 1'b1; addr[1] = 15'h0400; wdata[1] = 32'h1;
        step();
        wr[1] = 1'b0; rd[1] = 1'b1;
        step();
        rd[1] = 1'b0;
        $display("oor: addr 0400 -> %h err %b", rword[1], err[1]);
        checks++;
        if (rword[1] !== 32'hDEAD_BEEF) begin
            $display("FAIL oor_data got %h exp %h", rword[1], 32'hDEAD_BEEF);
            errors++;
        end
        checks++;
        if (err[1] !== 1'b1) begin
            $display("FAIL oor_error got %b exp 1", err[1]);
            errors++;
        end
        wr[1] = 1'b1; addr[1] = 15'h03FF; wdata[1] = 32'h0000_0077;
        step();
        wr[1] = 1'b0; rd[1] = 1'b1;
        step();
        rd[1] = 1'b0;
        $display("oor: addr 03ff -> %h err %b", rword[1], err[1]);
        checks++;
        if (rword[1] !== 32'h0000_0077) begin
            $display("FAIL oor_inrange_data got %h exp %h", rword[1], 32'h0000_0077);
            errors++;
        end
        checks++;
        if (err[1] !== 1'b1) begin
            $display("FAIL oor_error_sticky got %b exp 1", err[1]);
            errors++;
        end
        checks++;
        if (stats[1] !== 32'h0002_0002) begin
            $display("FAIL oor_stats got %h exp %h", stats[1], 32'h0002_0002);
            errors++;
        end
    endtask

    task automatic test_init_fill();
        rst_n[2] = 1'b0;
        wr[2] = 1'b1; rd[2] = 1'b1; addr[2] = 15'h0003; wdata[2] = 32'h1234_5678;
        step();
        checks++;
        if (ready[2] !== 1'b0) begin
            $display("FAIL init_ready_in_reset got %b exp 0", ready[2]);
            errors++;
        end
        rst_n[2] = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 15) begin
                checks++;
                if (ready[2] !== 1'b0) begin
                    $display("FAIL init_ready_c15 got %b exp 0", ready[2]);
                    errors++;
                end
            end
        end
        wr[2] = 1'b0; rd[2] = 1'b0;
        $display("init: ready %b after 16 edges", ready[2]);
        checks++;
        if (ready[2] !== 1'b1) begin
            $display("FAIL init_ready_c16 got %b exp 1", ready[2]);
            errors++;
        end
        checks++;
        if (stats[2] !== 32'h0) begin
            $display("FAIL init_stats got %h exp %h", stats[2], 32'h0);
            errors++;
        end
        checks++;
        if (rword[2] !== 32'h0) begin
            $display("FAIL init_rword got %h exp %h", rword[2], 32'h0);
            errors++;
        end
        rd[2] = 1'b1; addr[2] = 15'h0005;
        step();
        $display("init: addr 0005 -> %h", rword[2]);
        checks++;
        if (rword[2] !== 32'h0005_FFFA) begin
            $display("FAIL init_word5 got %h exp %h", rword[2], 32'h0005_FFFA);
            errors++;
        end
        addr[2] = 15'h0003;
        step();
        rd[2] = 1'b0;
        $display("init: addr 0003 -> %h", rword[2]);
        checks++;
        if (rword[2] !== 32'h0003_FFFC) begin
            $display("FAIL init_word3 got %h exp %h", rword[2], 32'h0003_FFFC);
            errors++;
        end
        checks++;
        if (stats[2] !== 32'h0002_0000) begin
            $display("FAIL init_stats_run got %h exp %h", stats[2], 32'h0002_0000);
            errors++;
        end
    endtask

    task automatic test_latency3_reset();
        logic [31:0] vals [3];
        vals[0] = 32'h1111_1111;
        vals[1] = 32'h2222_2222;
        vals[2] = 32'h3333_3333;
        for (int i = 0; i < 3; i++) begin
            wr[3] = 1'b1; addr[3] = 15'h0010 + 15'(i); wdata[3] = vals[i];
            step();
        end
        wr[3] = 1'b0;
        rd[3] = 1'b1; addr[3] = 15'h0010;
        step();
        addr[3] = 15'h0011;
        step();
        checks++;
        if (rword[3] !== 32'h0) begin
            $display("FAIL l3_early got %h exp %h", rword[3], 32'h0);
            errors++;
        end
        addr[3] = 15'h0012;
        step();
        rd[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            $display("l3: result %0d -> %h", i, rword[3]);
            checks++;
            if (rword[3] !== vals[i]) begin
                $display("FAIL l3_word%0d got %h exp %h", i, rword[3], vals[i]);
                errors++;
            end
        end
        checks++;
        if (stats[3] !== 32'h0003_0003) begin
            $display("FAIL l3_stats got %h exp %h", stats[3], 32'h0003_0003);
            errors++;
        end
        // Three reads in flight, reset lands after two edges.
        rd[3] = 1'b1; addr[3] = 15'h0010;
        step();
        addr[3] = 15'h0011;
        step();
        addr[3] = 15'h0012;
        rst_n[3] = 1'b0;
        #1;
        $display("l3: reset mid-stream rword %h", rword[3]);
        checks++;
        if (rword[3] !== 32'h0) begin
            $display("FAIL l3_reset_rword got %h exp %h", rword[3], 32'h0);
            errors++;
        end
        checks++;
        if (stats[3] !== 32'h0) begin
            $display("FAIL l3_reset_stats got %h exp %h", stats[3], 32'h0);
            errors++;
        end
        step();
        step();
        rd[3] = 1'b0;
        rst_n[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rword[3] !== 32'h0) begin
                $display("FAIL l3_stale%0d got %h exp %h", i, rword[3], 32'h0);
                errors++;
            end
        end
        checks++;
        if (stats[3] !== 32'h0) begin
            $display("FAIL l3_post_stats got %h exp %h", stats[3], 32'h0);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_refill_burst();
        test_simultaneous();
        test_out_of_range();
        test_init_fill();
        test_latency3_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/main_memory.md
# main_memory

Word-addressed main-memory responder for the L2 cache's memory-side bus: it answers `MM_read_request`/`MM_write_request` with a fixed, parameterised read latency. It is the far end of the L2 refill and write-through path. The L2 supplies its own miss penalty, so this block adds only pipeline latency. It also provides optional power-on pattern fill, out-of-range protection and transaction statistics.

## Interface
- `DATA_W`, 32, word width.
- `ADDR_W`, 15, word-address width (matches L2 `MM_word_address`).
- `DEPTH`, 32768, implemented words; addresses ≥ `DEPTH` are out of range.
- `READ_LATENCY`, 1, edges from address sampling to data update; legal 1..4.
- `INIT_ON_RESET`, 0, 1 = fill word i with {i[15:0],~i[15:0]} after reset.

Ports:
- `clk` in 1 system clock, rising edge.
- `reset` in 1 asynchronous, active-low reset.
- `MM_word_address` in `ADDR_W` word address, shared by reads and writes.
- `MM_read_request` in 1 read strobe, level-sampled every edge.
- `MM_write_request` in 1 write strobe, level-sampled every edge.
- `MM_write_word` in `DATA_W` write data.
- `MM_read_word` out `DATA_W` registered read data.
- `mm_ready` out 1 high when requests are accepted (low during init fill).
- `mm_error` out 1 sticky flag: an out-of-range access has occurred.
- `mm_statistics` out 32 {read_count[15:0], write_count[15:0]}.

## Operation
- States: `INIT`, `RUN`. Reset enters `INIT` if `INIT_ON_RESET`=1, otherwise `RUN`.
- `INIT`:
  - One write per cycle; fill counter runs 0..`DEPTH`-1.
  - Requests are ignored and not counted.
  - After writing word `DEPTH`-1, go to `RUN` on the next edge.
- `RUN`, per edge:
  - Write: if `MM_write_request`=1 and address < `DEPTH`, store `MM_write_word` at the address; write_count +1.
  - Read: if `MM_read_request`=1, push {address, in-range} into the read pipeline; read_count +1.
  - Both high on the same edge: the write is performed, and the read returns the new data (write-first).
  - Neither high: no action; `MM_read_word` holds its last value.
- Pipeline output:
  - In-range entry: `MM_read_word` loads the array word. The array is read at the output stage, so a write to that address landing before output is visible.
  - Out-of-range entry: `MM_read_word` loads 32'hDEADBEEF.
- Out-of-range:
  - Writes are dropped.
  - Any out-of-range read or write sets `mm_error`; only reset clears it.
  - Out-of-range accesses are still counted.
- Counters are 16 bits each and wrap from 16'hFFFF to 0.
- Array contents are not cleared by reset when `INIT_ON_RESET`=0; contents persist across reset.

## Timing
- Reset values: `MM_read_word`=0, `mm_error`=0, `mm_statistics`=0, pipeline empty, fill counter 0.
- `mm_ready`: 0 during reset when `INIT_ON_RESET`=1, else 1. It is 0 throughout `INIT` and rises on the edge entering `RUN`.
- Read latency:
  - Address sampled at edge k with `MM_read_request`=1.
  - Data appears after edge k+`READ_LATENCY`-1 and is stable until the next pipeline output.
- `READ_LATENCY`=1: a sequential address stream presented one per cycle returns one word per cycle, lagging by one cycle. This is the L2 refill pattern: 16 addresses over 16 cycles, sampled from the third cycle on.
- Reads are fully pipelined; one new read is accepted every cycle.
- Write occurs at the edge where `MM_write_request`=1. A read of the same address sampled at the next edge returns the new data.
- Reset asserted mid-operation:
  - In-flight reads are discarded; `MM_read_word` goes to 0 immediately.
  - A partially completed `INIT` restarts from word 0.

## Test plan
- Write/read-back: write 32'hA5A5_0001 to 15'h0123. Next cycle read 0x0123 → `MM_read_word`=32'hA5A5_0001 after one edge; `mm_statistics`=32'h0001_0001.
- Refill burst (`READ_LATENCY`=1): preload words 0x1230..0x123F = 0..15, then present addresses 0x1230..0x123F on consecutive cycles → words 0..15 appear on consecutive cycles, each one cycle after its address.
- Simultaneous read+write: write 32'h0000_BEEF and read 0x0040 on the same edge → read returns 32'h0000_BEEF; read and write counts both increment.
- Out-of-range (`DEPTH`=1024):
  - Write 32'h1 to 0x0400, then read 0x0400 → 32'hDEADBEEF; `mm_error`=1.
  - A subsequent in-range read still works and `mm_error` stays 1.
- Init fill (`INIT_ON_RESET`=1, `DEPTH`=16):
  - Release reset → `mm_ready` rises 16 cycles later.
  - Read of address 5 returns 32'h0005_FFFA.
  - A request issued during `INIT` is ignored and counts stay 0.
- `READ_LATENCY`=3 with reset mid-stream: issue 3 reads, assert reset after 2 edges → `MM_read_word`=0 immediately. After release, no stale data emerges and counters are 0.
